// File: rtl/warp_scheduler.sv
// Round-robin warp issue scheduler: tracks per-warp state and PC, offers one READY
// warp per cycle to the shared pipeline and reports kernel completion.
module warp_scheduler #(
    parameter int NUM_WARPS             = 2,
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int WARP_BITS             = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [NUM_WARPS-1:0]             warp_enable,
    input  logic                             issue_ready,
    output logic                             issue_valid,
    output logic [WARP_BITS-1:0]             issue_warp,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] issue_pc,
    input  logic                             retire_valid,
    input  logic [WARP_BITS-1:0]             retire_warp,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] retire_next_pc,
    input  logic                             retire_ret,
    input  logic                             retire_mem,
    input  logic                             mem_done_valid,
    input  logic [WARP_BITS-1:0]             mem_done_warp,
    output logic [NUM_WARPS-1:0]             warp_active,
    output logic                             done,
    output logic                             protocol_error
);

    if (NUM_WARPS < 1 || NUM_WARPS > 8 || THREADS_PER_BLOCK < 1) begin : g_bad_params
        $error("warp_scheduler: NUM_WARPS must be 1..8 and THREADS_PER_BLOCK at least 1");
    end

    typedef enum logic [2:0] {
        W_IDLE     = 3'd0,
        W_READY    = 3'd1,
        W_ISSUED   = 3'd2,
        W_WAIT_MEM = 3'd3,
        W_DONE     = 3'd4
    } warp_state_t;

    warp_state_t                      state [NUM_WARPS];
    logic [PROGRAM_MEM_ADDR_BITS-1:0] pc    [NUM_WARPS];
    logic                             running;
    logic [WARP_BITS-1:0]             rr_ptr;

    logic                 any_ready;
    logic [WARP_BITS-1:0] winner;
    logic [WARP_BITS-1:0] next_rr;
    logic                 do_issue;
    logic                 retire_ok;
    logic                 retire_bad;
    logic                 mem_ok;
    logic                 mem_bad;
    logic                 any_active;

    // Scan from rr_ptr upwards with wrap; the first READY warp wins.
    always_comb begin
        int idx;
        logic [WARP_BITS-1:0] cand;
        idx       = 0;
        cand      = '0;
        any_ready = 1'b0;
        winner    = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_WARPS) begin
                idx = idx - NUM_WARPS;
            end
            cand = WARP_BITS'(idx);
            if (!any_ready && state[cand] == W_READY) begin
                any_ready = 1'b1;
                winner    = cand;
            end
        end
    end

    always_comb begin
        warp_active = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            warp_active[i] = (state[i] == W_READY) || (state[i] == W_ISSUED) ||
                             (state[i] == W_WAIT_MEM);
        end
    end

    assign any_active  = |warp_active;
    assign issue_valid = running && any_ready;
    assign issue_warp  = winner;
    assign issue_pc    = any_ready ? pc[winner] : '0;
    assign do_issue    = issue_valid && issue_ready;
    assign next_rr     = (int'(winner) == NUM_WARPS - 1) ? '0 : winner + 1'b1;

    // Events are judged against registered state, so a retire and a mem_done aimed
    // at the same warp can never both be legal.
    assign retire_ok  = retire_valid && (int'(retire_warp) < NUM_WARPS) &&
                        (state[retire_warp] == W_ISSUED);
    assign retire_bad = retire_valid && !retire_ok;
    assign mem_ok     = mem_done_valid && (int'(mem_done_warp) < NUM_WARPS) &&
                        (state[mem_done_warp] == W_WAIT_MEM);
    assign mem_bad    = mem_done_valid && !mem_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                state[i] <= W_IDLE;
                pc[i]    <= '0;
            end
            running        <= 1'b0;
            done           <= 1'b0;
            protocol_error <= 1'b0;
            rr_ptr         <= '0;
        end else begin
            if (start && !running) begin
                running <= 1'b1;
                done    <= 1'b0;
                for (int i = 0; i < NUM_WARPS; i++) begin
                    state[i] <= warp_enable[i] ? W_READY : W_IDLE;
                    pc[i]    <= '0;
                end
            end else begin
                if (do_issue) begin
                    state[winner] <= W_ISSUED;
                    rr_ptr        <= next_rr;
                end
                if (retire_ok) begin
                    pc[retire_warp] <= retire_next_pc;
                    if (retire_ret) begin
                        state[retire_warp] <= W_DONE;
                    end else if (retire_mem) begin
                        state[retire_warp] <= W_WAIT_MEM;
                    end else begin
                        state[retire_warp] <= W_READY;
                    end
                end
                if (mem_ok) begin
                    state[mem_done_warp] <= W_READY;
                end
                if (running && !any_active) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
            if (retire_bad || mem_bad) begin
                protocol_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_warp_scheduler.sv
// Scoreboard bench for warp_scheduler with four warps: directed issue sequences are
// queued up front and a negedge monitor checks every accepted issue against them.
module tb_warp_scheduler;

    localparam int NW = 4;
    localparam int AW = 8;
    localparam int WB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NW-1:0] warp_enable;
    logic          issue_ready;
    logic          issue_valid;
    logic [WB-1:0] issue_warp;
    logic [AW-1:0] issue_pc;
    logic          retire_valid;
    logic [WB-1:0] retire_warp;
    logic [AW-1:0] retire_next_pc;
    logic          retire_ret;
    logic          retire_mem;
    logic          mem_done_valid;
    logic [WB-1:0] mem_done_warp;
    logic [NW-1:0] warp_active;
    logic          done;
    logic          protocol_error;

    int errors = 0;
    int checks = 0;

    logic [WB+AW-1:0] exp_q[$];
    logic [WB+AW-1:0] mon_exp;
    logic [NW-1:0]    ret_mask;
    logic [NW-1:0]    mem_mask;
    logic             hs;
    logic [WB-1:0]    hs_warp;
    logic [AW-1:0]    hs_pc;

    warp_scheduler #(
        .NUM_WARPS(NW),
        .THREADS_PER_BLOCK(4),
        .PROGRAM_MEM_ADDR_BITS(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .warp_enable(warp_enable),
        .issue_ready(issue_ready),
        .issue_valid(issue_valid),
        .issue_warp(issue_warp),
        .issue_pc(issue_pc),
        .retire_valid(retire_valid),
        .retire_warp(retire_warp),
        .retire_next_pc(retire_next_pc),
        .retire_ret(retire_ret),
        .retire_mem(retire_mem),
        .mem_done_valid(mem_done_valid),
        .mem_done_warp(mem_done_warp),
        .warp_active(warp_active),
        .done(done),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expectIssue(input int w, input int p);
        exp_q.push_back({WB'(w), AW'(p)});
    endtask

    // One clock: sample the handshake at negedge, then after the edge play the
    // pipeline, retiring last cycle's issue with pc+1 and the per-warp ret/mem flags.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            hs      = (issue_valid === 1'b1) && (issue_ready === 1'b1);
            hs_warp = issue_warp;
            hs_pc   = issue_pc;
            @(posedge clk);
            #1;
            start          = 1'b0;
            mem_done_valid = 1'b0;
            mem_done_warp  = '0;
            retire_valid   = hs;
            retire_warp    = hs ? hs_warp : '0;
            retire_next_pc = hs ? hs_pc + 1'b1 : '0;
            retire_ret     = hs && ret_mask[hs_warp];
            retire_mem     = hs && mem_mask[hs_warp];
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_issue_valid", 32'(issue_valid), 32'd0);
        checkOutput("rst_issue_warp", 32'(issue_warp), 32'd0);
        checkOutput("rst_issue_pc", 32'(issue_pc), 32'd0);
        checkOutput("rst_warp_active", 32'(warp_active), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_protocol_error", 32'(protocol_error), 32'd0);
    endtask

    // Monitor: every accepted issue must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset === 1'b0 && issue_valid === 1'b1 && issue_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_issue: got warp %0d pc %0d, expected no issue",
                         issue_warp, issue_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("issue_warp", 32'(issue_warp), 32'(mon_exp[WB+AW-1:AW]));
                checkOutput("issue_pc", 32'(issue_pc), 32'(mon_exp[AW-1:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        warp_enable    = '0;
        issue_ready    = 1'b0;
        retire_valid   = 1'b0;
        retire_warp    = '0;
        retire_next_pc = '0;
        retire_ret     = 1'b0;
        retire_mem     = 1'b0;
        mem_done_valid = 1'b0;
        mem_done_warp  = '0;
        ret_mask       = '0;
        mem_mask       = '0;

        applyStimulus(2);
        reset = 1'b0;
        checkResetOutputs();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("idle_no_valid", 32'(issue_valid), 32'd0);
        end

        $display("[TB] round-robin over warps 0,1,3");
        warp_enable = 4'b1011;
        issue_ready = 1'b1;
        start       = 1'b1;
        expectIssue(0, 0); expectIssue(1, 0); expectIssue(3, 0);
        expectIssue(0, 1); expectIssue(1, 1); expectIssue(3, 1);
        applyStimulus(1);
        checkOutput("start_active", 32'(warp_active), 32'hB);
        checkOutput("start_valid", 32'(issue_valid), 32'd1);
        applyStimulus(6);

        $display("[TB] backpressure");
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", 32'(issue_valid), 32'd1);
            checkOutput("bp_warp", 32'(issue_warp), 32'd0);
            checkOutput("bp_pc", 32'(issue_pc), 32'd2);
            applyStimulus(1);
        end

        $display("[TB] memory stall on warp 0");
        issue_ready = 1'b1;
        mem_mask[0] = 1'b1;
        expectIssue(0, 2); expectIssue(1, 2); expectIssue(3, 2);
        expectIssue(1, 3); expectIssue(3, 3); expectIssue(1, 4);
        applyStimulus(6);
        checkOutput("stall_active", 32'(warp_active), 32'hB);
        mem_done_valid = 1'b1;
        mem_done_warp  = 2'd0;
        mem_mask[0]    = 1'b0;
        expectIssue(3, 4); expectIssue(0, 3); expectIssue(1, 5); expectIssue(3, 5);
        applyStimulus(4);

        $display("[TB] protocol errors");
        issue_ready    = 1'b0;
        mem_done_valid = 1'b1;
        mem_done_warp  = 2'd1;
        applyStimulus(1);
        checkOutput("perr_mem_done", 32'(protocol_error), 32'd1);
        checkOutput("perr_mem_active", 32'(warp_active), 32'hB);
        retire_valid   = 1'b1;
        retire_warp    = 2'd2;
        retire_next_pc = 8'h55;
        retire_ret     = 1'b0;
        retire_mem     = 1'b0;
        applyStimulus(1);
        checkOutput("perr_retire", 32'(protocol_error), 32'd1);
        checkOutput("perr_retire_active", 32'(warp_active), 32'hB);

        $display("[TB] completion");
        ret_mask    = 4'b1111;
        issue_ready = 1'b1;
        expectIssue(0, 4); expectIssue(1, 6); expectIssue(3, 6);
        applyStimulus(3);
        applyStimulus(1);
        checkOutput("last_ret_done", 32'(done), 32'd0);
        checkOutput("last_ret_active", 32'(warp_active), 32'd0);
        checkOutput("last_ret_valid", 32'(issue_valid), 32'd0);
        applyStimulus(1);
        checkOutput("done_high", 32'(done), 32'd1);

        $display("[TB] relaunch");
        ret_mask    = '0;
        warp_enable = 4'b0110;
        start       = 1'b1;
        expectIssue(1, 0); expectIssue(2, 0); expectIssue(1, 1);
        applyStimulus(1);
        checkOutput("relaunch_done", 32'(done), 32'd0);
        checkOutput("relaunch_active", 32'(warp_active), 32'h6);
        applyStimulus(3);
        issue_ready = 1'b0;

        $display("[TB] asynchronous reset mid-kernel");
        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs();
        retire_valid = 1'b0;
        applyStimulus(2);
        reset = 1'b0;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        issue_ready = 1'b1;
        applyStimulus(2);
        checkOutput("post_reset_valid", 32'(issue_valid), 32'd0);
        checkOutput("post_reset_done", 32'(done), 32'd0);

        $display("[TB] start with no warps enabled");
        warp_enable = '0;
        start       = 1'b1;
        applyStimulus(1);
        checkOutput("empty_start_done0", 32'(done), 32'd0);
        applyStimulus(1);
        checkOutput("empty_start_done1", 32'(done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
